// File: rtl/intt8_core.sv
// Sequential 8-point inverse NTT over Z_MOD using a single multiply-accumulate.
// Loads 8 coefficients, runs 64 MAC cycles, then streams 8 scaled results out.
module intt8_core #(
  parameter int unsigned MOD   = 17,
  parameter int unsigned IROOT = 2,
  parameter int unsigned NINV  = 15,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 2 * DW;
  localparam logic [PW-1:0] MODW  = PW'(MOD);
  localparam logic [PW-1:0] NINVW = PW'(NINV);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    icnt;
  logic [2:0]    ci;
  logic [2:0]    cj;
  logic [2:0]    ocnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] x_mem [N];
  logic [DW-1:0] y_mem [N];
  logic [DW-1:0] itw   [N];

  logic [2:0]    k;
  logic [PW-1:0] prod;
  logic [PW-1:0] term;
  logic [PW-1:0] acc_sel;
  logic [PW-1:0] sum;
  logic [PW-1:0] scaled;

  // IROOT^e mod MOD, evaluated on constants only
  function automatic logic [DW-1:0] pow_mod(input int unsigned e);
    int unsigned p;
    p = 1;
    for (int unsigned n = 0; n < e; n++) begin
      p = (p * IROOT) % MOD;
    end
    return DW'(p);
  endfunction

  // Twiddle ROM: itw[k] = IROOT^k mod MOD
  for (genvar g = 0; g < N; g++) begin : g_rom
    assign itw[g] = pow_mod(g);
  end

  // MAC datapath: reduced term, running sum and final NINV scaling
  always_comb begin
    k       = ci * cj;
    prod    = PW'(x_mem[ci]) * PW'(itw[k]);
    term    = prod % MODW;
    acc_sel = (ci == 3'd0) ? '0 : PW'(acc);
    sum     = (acc_sel + term) % MODW;
    scaled  = (sum * NINVW) % MODW;
  end

  // Control FSM, storage and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      icnt      <= '0;
      ci        <= '0;
      cj        <= '0;
      ocnt      <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int n = 0; n < N; n++) begin
        x_mem[n] <= '0;
        y_mem[n] <= '0;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            x_mem[icnt] <= DW'(32'(in_data) % MOD);
            if (icnt == 3'd7) begin
              icnt     <= '0;
              state    <= ST_COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              icnt <= 3'(icnt + 3'd1);
            end
          end
        end
        ST_COMPUTE: begin
          acc <= DW'(sum);
          if (ci == 3'd7) begin
            y_mem[cj] <= DW'(scaled);
            ci        <= '0;
            if (cj == 3'd7) begin
              cj        <= '0;
              state     <= ST_OUT;
              out_valid <= 1'b1;
              out_data  <= y_mem[0];
              out_last  <= 1'b0;
            end else begin
              cj <= 3'(cj + 3'd1);
            end
          end else begin
            ci <= 3'(ci + 3'd1);
          end
        end
        ST_OUT: begin
          if (out_valid && out_ready) begin
            if (ocnt == 3'd7) begin
              ocnt      <= '0;
              state     <= ST_LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              ocnt     <= 3'(ocnt + 3'd1);
              out_data <= y_mem[3'(ocnt + 3'd1)];
              out_last <= (ocnt == 3'd6);
            end
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
